// File: rtl/audio_sample_fifo.sv
// Single-clock PCM frame buffer in front of the HDMI audio packetiser.
// Optional half-full prefill (FILL/RUN) is built when AUDIO_FIFO_PREFILL_EN is defined.
module audio_sample_fifo #(
   parameter int AUDIO_DW   = 16,
   parameter int CHANNELS   = 2,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           in_valid,
   input  logic [AUDIO_DW*CHANNELS-1:0]   in_data,
   input  logic                           audio_sample,
   output logic [AUDIO_DW*CHANNELS-1:0]   out_data,
   output logic [DEPTH_LOG2:0]            level,
   output logic                           overrun,
   output logic                           underrun
);

   localparam int FW = AUDIO_DW * CHANNELS;
   localparam int D  = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2+1)'(D);

   logic [FW-1:0]         r_mem [D];
   logic [DEPTH_LOG2-1:0] r_wp;
   logic [DEPTH_LOG2-1:0] r_rp;
   logic [DEPTH_LOG2:0]   r_level;
   logic [FW-1:0]         r_out;
   logic                  r_overrun;
   logic                  r_underrun;

   logic w_run;
   logic w_read_req;
   logic w_pop;
   logic w_wr;
   logic w_drop;
   logic w_underrun_evt;

   // A read request only counts once playback is running; in FILL it is ignored entirely.
   assign w_read_req     = enable && audio_sample && w_run;
   assign w_pop          = w_read_req && (r_level != '0);
   assign w_underrun_evt = w_read_req && (r_level == '0);
   assign w_wr           = enable && in_valid && ((r_level != L_DEPTH) || w_pop);
   assign w_drop         = enable && in_valid && !w_wr;

`ifdef AUDIO_FIFO_PREFILL_EN
   localparam logic [DEPTH_LOG2:0] L_HALF = (DEPTH_LOG2+1)'(D / 2);

   typedef enum logic {ST_FILL, ST_RUN} state_t;
   state_t r_state;
   state_t w_state_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Threshold uses the registered level, so RUN starts one cycle after reaching half-full.
   always_comb begin
      w_state_next = r_state;
      if (!enable) begin
         w_state_next = ST_FILL;
      end else begin
         case (r_state)
            ST_FILL: if (r_level >= L_HALF) w_state_next = ST_RUN;
            ST_RUN:  if (w_underrun_evt)    w_state_next = ST_FILL;
            default: w_state_next = ST_FILL;
         endcase
      end
   end

   assign w_run = (r_state == ST_RUN);
`else
   assign w_run = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wp] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_out      <= '0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else if (!enable) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_level    <= '0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_overrun  <= w_drop;
         r_underrun <= w_underrun_evt;
         if (w_wr) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp  <= r_rp + 1'b1;
            r_out <= r_mem[r_rp];
         end
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign out_data = enable ? r_out : in_data;
   assign level    = r_level;
   assign overrun  = r_overrun;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: directed steps plus random traffic against a queue-based model.
module tb_audio_sample_fifo;

   localparam int AUDIO_DW   = 16;
   localparam int CHANNELS   = 2;
   localparam int DEPTH_LOG2 = 4;
   localparam int FW         = AUDIO_DW * CHANNELS;
   localparam int D          = 2 ** DEPTH_LOG2;
`ifdef AUDIO_FIFO_PREFILL_EN
   localparam bit PREFILL = 1'b1;
`else
   localparam bit PREFILL = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  enable = 1'b0;
   logic                  in_valid = 1'b0;
   logic [FW-1:0]         in_data = '0;
   logic                  audio_sample = 1'b0;
   logic [FW-1:0]         out_data;
   logic [DEPTH_LOG2:0]   level;
   logic                  overrun;
   logic                  underrun;

   audio_sample_fifo #(
      .AUDIO_DW   (AUDIO_DW),
      .CHANNELS   (CHANNELS),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .audio_sample (audio_sample),
      .out_data     (out_data),
      .level        (level),
      .overrun      (overrun),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: stored frames in order, last popped frame, playback flag, pending pulses.
   logic [FW-1:0] q[$];
   logic [FW-1:0] m_out;
   bit            m_play;
   bit            m_ov;
   bit            m_un;

   function automatic logic [FW-1:0] fr(int n);
      return FW'(32'hA5000000 + n);
   endfunction

   task automatic chk(string tag, logic [FW-1:0] got, logic [FW-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_out  = '0;
      m_play = !PREFILL;
      m_ov   = 1'b0;
      m_un   = 1'b0;
   endtask

   task automatic model_edge(bit en, bit v, logic [FW-1:0] d, bit as);
      int  sz;
      bit  pop;
      bit  acc;
      sz   = q.size();
      m_ov = 1'b0;
      m_un = 1'b0;
      if (!en) begin
         q.delete();
         m_play = !PREFILL;
      end else begin
         pop  = m_play && as && (sz > 0);
         m_un = m_play && as && (sz == 0);
         acc  = v && ((sz < D) || pop);
         m_ov = v && !acc;
         if (pop) m_out = q.pop_front();
         if (acc) q.push_back(d);
         if (PREFILL) begin
            if (m_un) m_play = 1'b0;
            else if (!m_play && sz >= D / 2) m_play = 1'b1;
         end
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".out"},   out_data, enable ? m_out : in_data);
      chk({tag, ".level"}, FW'(level), FW'(q.size()));
      chk({tag, ".ovr"},   FW'(overrun), FW'(m_ov));
      chk({tag, ".udr"},   FW'(underrun), FW'(m_un));
   endtask

   task automatic step(string tag, bit en, bit v, logic [FW-1:0] d, bit as);
      enable       = en;
      in_valid     = v;
      in_data      = d;
      audio_sample = as;
      @(posedge clk);
      #1;
      model_edge(en, v, d, as);
      $display("%s en=%0b v=%0b d=%h as=%0b -> out=%h lvl=%0d ovr=%0b udr=%0b",
               tag, en, v, d, as, out_data, level, overrun, underrun);
      check_all(tag);
   endtask

   initial begin
      int prob_w;
      int prob_r;

      // Reset with bypass: output follows input combinationally.
      reset   = 1'b1;
      enable  = 1'b0;
      in_data = FW'(32'h1234_5678);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all("reset");
      chk("reset.bypass", out_data, FW'(32'h1234_5678));
      @(negedge clk);
      reset = 1'b0;

      // Prefill: 7 frames, early read, 8th frame, threshold cycle, first real read.
      for (int i = 1; i <= 7; i++) step("pre_wr", 1, 1, fr(i), 0);
      step("pre_rd_early", 1, 0, '0, 1);
      step("pre_wr8", 1, 1, fr(8), 0);
      step("pre_thresh", 1, 0, '0, 1);
      step("pre_rd1", 1, 0, '0, 1);

      // Flush, then overrun on the 17th write.
      step("flush_a", 0, 0, '0, 0);
      for (int i = 1; i <= 17; i++) step("ovr_wr", 1, 1, fr(100 + i), 0);
      step("full_rw", 1, 1, fr(200), 1);

      // Drain everything, then underrun, then recovery.
      for (int i = 0; i < 40 && q.size() > 0; i++) step("drain", 1, 0, '0, 1);
      step("udr_rd", 1, 0, '0, 1);
      step("udr_idle", 1, 0, '0, 0);
      step("udr_wrx", 1, 1, fr(300), 0);
      step("udr_rdx", 1, 0, '0, 1);
      for (int i = 1; i <= 8; i++) step("refill", 1, 1, fr(310 + i), 0);
      step("refill_idle", 1, 0, '0, 0);
      step("refill_rd", 1, 0, '0, 1);

      // Bring level to 5 while running, then a one-cycle flush.
      for (int i = 0; i < 40 && q.size() > 0; i++) step("drain2", 1, 0, '0, 1);
      for (int i = 1; i <= 8; i++) step("l5_wr", 1, 1, fr(400 + i), 0);
      step("l5_idle", 1, 0, '0, 0);
      for (int i = 0; i < 3; i++) step("l5_rd", 1, 0, '0, 1);
      chk("l5.level", FW'(level), FW'(5));
      step("flush_b", 0, 1, fr(499), 1);
      step("post_flush", 1, 0, '0, 0);
      step("post_rd1", 1, 0, '0, 1);
      step("post_rd2", 1, 0, '0, 1);

      // Reset in the middle of traffic.
      for (int i = 1; i <= 6; i++) step("mr_wr", 1, 1, fr(500 + i), 0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("mid_reset");
      @(negedge clk);
      reset = 1'b0;

      // Random traffic: write-heavy phase followed by read-heavy phase.
      for (int i = 0; i < 400; i++) begin
         prob_w = (i < 200) ? 70 : 30;
         prob_r = (i < 200) ? 30 : 70;
         step("rand",
              $urandom_range(0, 29) != 0,
              $urandom_range(0, 99) < prob_w,
              FW'($urandom()),
              $urandom_range(0, 99) < prob_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
